// File: rtl/vga_tile_render.sv
// Tile-map pixel pipeline: counters -> map RAM -> pattern ROM -> 12-bit RGB, with HS/VS/blank realigned.
// Latency: fixed 4 pixel_clk cycles from hcounter/vcounter/blank/hs_in/vs_in to rgb/hs_out/vs_out/blank_out.
// Backpressure: none; one pixel in and one pixel out every cycle, the pipeline never stalls.
// Optional build macro SPRITE_EN adds a 16x16 single-colour sprite overlay (sprite_x/sprite_y/sprite_color).
module vga_tile_render #(
  parameter int          MAP_COLS   = 80,
  parameter int          MAP_ROWS   = 60,
  parameter logic [11:0] BG_COLOR   = 12'h000,
  parameter logic [11:0] WALL_COLOR = 12'h00F,
  parameter logic [11:0] DOT_COLOR  = 12'hFCA,
  parameter int          BLINK_BIT  = 4
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic [10:0] hcounter,
  input  logic [10:0] vcounter,
  input  logic        blank,
  input  logic        hs_in,
  input  logic        vs_in,
`ifdef SPRITE_EN
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic [11:0] sprite_color,
`endif
  output logic [12:0] map_addr,
  input  logic [3:0]  map_data,
  output logic [6:0]  pat_addr,
  input  logic [7:0]  pat_data,
  output logic [11:0] rgb,
  output logic        hs_out,
  output logic        vs_out,
  output logic        blank_out,
  output logic        frame_tick
);

  localparam logic [10:0] H_VISIBLE = 11'(MAP_COLS * 8);
  localparam logic [10:0] V_VISIBLE = 11'(MAP_ROWS * 8);

  // Stage 1 registers
  logic [2:0]  s1_hlo;
  logic [2:0]  s1_vlo;
  logic        s1_blank;
  logic        s1_hs;
  logic        s1_vs;
  // Stage 2 registers
  logic [3:0]  s2_code;
  logic [2:0]  s2_hlo;
  logic        s2_blank;
  logic        s2_hs;
  logic        s2_vs;
  // Stage 3 registers
  logic        s3_pix;
  logic [3:0]  s3_code;
  logic        s3_blink;
  logic        s3_blank;
  logic        s3_hs;
  logic        s3_vs;
  // Frame counter
  logic        vs_prev;
  logic [5:0]  frame_cnt;
  logic        vs_fall;
  // Combinational next values
  logic [12:0] map_row;
  logic [12:0] map_col;
  logic [12:0] map_addr_nxt;
  logic [11:0] rgb_nxt;

`ifdef SPRITE_EN
  logic [10:0] s1_h;
  logic [10:0] s1_v;
  logic [10:0] s2_h;
  logic [10:0] s2_v;
  logic [10:0] s3_h;
  logic [10:0] s3_v;
  logic [9:0]  spr_x_q;
  logic [9:0]  spr_y_q;
  logic        spr_hit;
`endif

  assign vs_fall = vs_prev & ~vs_in;

  // Tile index for the incoming pixel; off-screen counters park the address at 0
  always_comb begin
    map_row      = {6'd0, vcounter[9:3]};
    map_col      = {6'd0, hcounter[9:3]};
    map_addr_nxt = map_row * 13'(MAP_COLS) + map_col;
    if ((hcounter >= H_VISIBLE) || (vcounter >= V_VISIBLE)) begin
      map_addr_nxt = '0;
    end
  end

  // S1: latch timing inputs and issue the tile-map read
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      map_addr <= '0;
      s1_hlo   <= '0;
      s1_vlo   <= '0;
      s1_blank <= 1'b1;
      s1_hs    <= 1'b1;
      s1_vs    <= 1'b1;
    end else begin
      map_addr <= map_addr_nxt;
      s1_hlo   <= hcounter[2:0];
      s1_vlo   <= vcounter[2:0];
      s1_blank <= blank;
      s1_hs    <= hs_in;
      s1_vs    <= vs_in;
    end
  end

  // S2: tile code arrives, issue the glyph-row read
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      pat_addr <= '0;
      s2_code  <= '0;
      s2_hlo   <= '0;
      s2_blank <= 1'b1;
      s2_hs    <= 1'b1;
      s2_vs    <= 1'b1;
    end else begin
      pat_addr <= {map_data, s1_vlo};
      s2_code  <= map_data;
      s2_hlo   <= s1_hlo;
      s2_blank <= s1_blank;
      s2_hs    <= s1_hs;
      s2_vs    <= s1_vs;
    end
  end

  // S3: glyph row arrives, pick this pixel's bit (bit 7 is leftmost) and sample blink state
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      s3_pix   <= 1'b0;
      s3_code  <= '0;
      s3_blink <= 1'b0;
      s3_blank <= 1'b1;
      s3_hs    <= 1'b1;
      s3_vs    <= 1'b1;
    end else begin
      s3_pix   <= pat_data[3'd7 - s2_hlo];
      s3_code  <= s2_code;
      s3_blink <= frame_cnt[BLINK_BIT];
      s3_blank <= s2_blank;
      s3_hs    <= s2_hs;
      s3_vs    <= s2_vs;
    end
  end

`ifdef SPRITE_EN
  // Full counters travel alongside the pipe so the sprite test sees the same pixel as the tiles
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      s1_h <= '0;
      s1_v <= '0;
      s2_h <= '0;
      s2_v <= '0;
      s3_h <= '0;
      s3_v <= '0;
    end else begin
      s1_h <= hcounter;
      s1_v <= vcounter;
      s2_h <= s1_h;
      s2_v <= s1_v;
      s3_h <= s2_h;
      s3_v <= s2_v;
    end
  end

  // Sprite position only moves at frame boundaries so a frame is never torn
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      spr_x_q <= '0;
      spr_y_q <= '0;
    end else if (frame_tick) begin
      spr_x_q <= sprite_x;
      spr_y_q <= sprite_y;
    end
  end

  // 16x16 window test against the latched sprite origin
  always_comb begin
    spr_hit = (s3_h >= {1'b0, spr_x_q}) && (s3_h <= ({1'b0, spr_x_q} + 11'd15)) &&
              (s3_v >= {1'b0, spr_y_q}) && (s3_v <= ({1'b0, spr_y_q} + 11'd15));
  end
`endif

  // Colour lookup: tile code selects palette, blanking forces black over everything
  always_comb begin
    rgb_nxt = BG_COLOR;
    if (s3_pix) begin
      case (s3_code)
        4'd0:    rgb_nxt = BG_COLOR;
        4'd2:    rgb_nxt = DOT_COLOR;
        4'd3:    rgb_nxt = s3_blink ? BG_COLOR : DOT_COLOR;
        default: rgb_nxt = WALL_COLOR;
      endcase
    end
`ifdef SPRITE_EN
    if (spr_hit) begin
      rgb_nxt = sprite_color;
    end
`endif
    if (s3_blank) begin
      rgb_nxt = '0;
    end
  end

  // S4: register the pixel colour and the realigned sync/blank
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      rgb       <= '0;
      hs_out    <= 1'b1;
      vs_out    <= 1'b1;
      blank_out <= 1'b1;
    end else begin
      rgb       <= rgb_nxt;
      hs_out    <= s3_hs;
      vs_out    <= s3_vs;
      blank_out <= s3_blank;
    end
  end

  // Frame counter advances on each VS falling edge, with a one-cycle tick the cycle after
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      vs_prev    <= 1'b1;
      frame_cnt  <= '0;
      frame_tick <= 1'b0;
    end else begin
      vs_prev    <= vs_in;
      frame_tick <= vs_fall;
      if (vs_fall) begin
        frame_cnt <= frame_cnt + 6'd1;
      end
    end
  end

endmodule
